ppu_fb_writer: RTL and testbench

Downstream stage of the PPU pixel pipeline. Consumes the 2-bit pixel stream and the current mode from the PPU and applies the BGP palette. It writes each shade into a double-buffered 160x144 framebuffer RAM that the video scan-out logic reads. At each V-blank it swaps banks, but only if a complete frame was written, so scan-out never displays a torn or partial frame.

---
 rtl/ppu_fb_writer.sv | 190 +++++++++++++++++++
 tb/tb_ppu_fb_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: applies the BGP palette to the PPU pixel stream and writes the
// shades into a double-buffered framebuffer. At V-blank the write and display
// banks swap only when a complete, clean frame was written, so scan-out never
// shows a torn or partial frame.
module ppu_fb_writer #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    input  logic [7:0]  bgp,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [1:0]  fb_data,
    output logic        disp_bank,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  line_cnt
);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LINE_WAIT = 2'd1,
        DRAW_LINE = 2'd2,
        VB        = 2'd3
    } state_t;

    localparam logic [1:0]  M_HBLANK  = 2'd0;
    localparam logic [1:0]  M_VBLANK  = 2'd1;
    localparam logic [1:0]  M_SCAN    = 2'd2;
    localparam logic [1:0]  M_DRAW    = 2'd3;
    localparam logic [7:0]  H_PIX_C   = 8'(H_PIX);
    localparam logic [7:0]  V_LINES_C = 8'(V_LINES);
    localparam logic [14:0] ROW_STEP  = 15'(H_PIX);

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [14:0] row_base_q;
    logic [7:0]  lines_ok_q;
    logic        ovf_q;
    logic        wbank_q;
    logic        fb_we_q;
    logic [15:0] fb_addr_q;
    logic [1:0]  fb_data_q;
    logic        disp_q;
    logic        done_q;
    logic        err_q;

    logic        vb_entry;
    logic        scan_entry;
    logic        draw_entry;
    logic        hblank_entry;
    logic        vb_check;
    logic        frame_ok;
    logic        pix_ok;
    logic [14:0] wr_addr;

    // Palette lookup: colour index n selects bgp bits [2n+1:2n].
    function automatic logic [1:0] pal_map(input logic [7:0] pal, input logic [1:0] idx);
        logic [1:0] shade;
        case (idx)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            default: shade = pal[7:6];
        endcase
        return shade;
    endfunction

    // Mode edge detection against the registered mode, plus frame/pixel qualifiers.
    always_comb begin
        vb_entry     = (mode_q != M_VBLANK) && (ppu_mode == M_VBLANK);
        scan_entry   = (mode_q == M_VBLANK) && (ppu_mode == M_SCAN);
        draw_entry   = (mode_q != M_DRAW)   && (ppu_mode == M_DRAW);
        hblank_entry = (mode_q == M_DRAW)   && (ppu_mode == M_HBLANK);
        // A V-blank edge while drawing or between lines closes the frame;
        // in DRAW_LINE it truncates the current line without advancing y.
        vb_check     = vb_entry && ((state_q == LINE_WAIT) || (state_q == DRAW_LINE));
        frame_ok     = (lines_ok_q == V_LINES_C) && !ovf_q;
        pix_ok       = px_valid && (x_q < H_PIX_C) && (y_q < V_LINES_C);
        wr_addr      = row_base_q + {7'd0, x_q};
    end

    // Frame/line state machine with registered framebuffer and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC_WAIT;
            mode_q     <= M_HBLANK;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            row_base_q <= 15'd0;
            lines_ok_q <= 8'd0;
            ovf_q      <= 1'b0;
            wbank_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= 16'd0;
            fb_data_q  <= 2'd0;
            disp_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mode_q  <= ppu_mode;
            fb_we_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            if (!lcd_en) begin
                // LCD off: drop everything collected so far and resync on
                // the next V_BLANK -> SCAN edge after re-enable.
                state_q    <= SYNC_WAIT;
                x_q        <= 8'd0;
                lines_ok_q <= 8'd0;
                ovf_q      <= 1'b0;
            end else if (vb_check) begin
                state_q <= VB;
                if (frame_ok) begin
                    wbank_q <= ~wbank_q;
                    disp_q  <= wbank_q;
                    done_q  <= 1'b1;
                end else begin
                    err_q   <= 1'b1;
                end
                lines_ok_q <= 8'd0;
                ovf_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    SYNC_WAIT: begin
                        if (scan_entry) begin
                            state_q    <= LINE_WAIT;
                            y_q        <= 8'd0;
                            row_base_q <= 15'd0;
                        end
                    end
                    LINE_WAIT: begin
                        if (draw_entry) begin
                            state_q <= DRAW_LINE;
                            x_q     <= 8'd0;
                        end
                    end
                    DRAW_LINE: begin
                        if (hblank_entry) begin
                            if (x_q == H_PIX_C) begin
                                lines_ok_q <= lines_ok_q + 8'd1;
                            end
                            if (y_q < V_LINES_C) begin
                                y_q <= y_q + 8'd1;
                            end
                            row_base_q <= row_base_q + ROW_STEP;
                            state_q    <= LINE_WAIT;
                        end else if (px_valid) begin
                            if (pix_ok) begin
                                fb_we_q   <= 1'b1;
                                fb_addr_q <= {wbank_q, wr_addr};
                                fb_data_q <= pal_map(bgp, px_in);
                                x_q       <= x_q + 8'd1;
                            end else begin
                                // Pixel beyond the visible area: the frame is suspect.
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                    VB: begin
                        if (scan_entry) begin
                            state_q    <= LINE_WAIT;
                            x_q        <= 8'd0;
                            y_q        <= 8'd0;
                            row_base_q <= 15'd0;
                        end
                    end
                    default: state_q <= SYNC_WAIT;
                endcase
            end
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign disp_bank  = disp_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign line_cnt   = y_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: palette mapping, full/incomplete frames,
// overflow, LCD disable resync and mid-frame reset.
module tb_ppu_fb_writer;

    logic        clk;
    logic        rst;
    logic        lcd_en;
    logic [1:0]  ppu_mode;
    logic [1:0]  px_in;
    logic        px_valid;
    logic [7:0]  bgp;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [1:0]  fb_data;
    logic        disp_bank;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  line_cnt;

    int          checks;
    int          errors;
    int          wr_cnt;
    int          done_cnt;
    int          err_cnt;
    logic [15:0] last_addr;
    logic [15:0] a0_addr;

    ppu_fb_writer #(.H_PIX(160), .V_LINES(144)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_en     (lcd_en),
        .ppu_mode   (ppu_mode),
        .px_in      (px_in),
        .px_valid   (px_valid),
        .bgp        (bgp),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .disp_bank  (disp_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .line_cnt   (line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (fb_we === 1'b1) begin
            wr_cnt++;
            last_addr = fb_addr;
            if (fb_addr[14:0] == 15'h00A0) a0_addr = fb_addr;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    endtask

    task automatic clear_stats();
        wr_cnt    = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        last_addr = 16'h0000;
        a0_addr   = 16'hFFFF;
    endtask

    // Push npix pixels (colour line%4, bgp assumed 0xE4) and check each result.
    task automatic push_pixels(input int line, input int npix, input logic bank, input bit exp_wr);
        logic [15:0] ea;
        logic [1:0]  pv;
        pv = 2'(line % 4);
        for (int i = 0; i < npix; i++) begin
            px_valid = 1'b1;
            px_in    = pv;
            tick();
            checks++;
            if (exp_wr && i < 160) begin
                ea = {bank, 15'(line * 160 + i)};
                if (fb_we !== 1'b1 || fb_addr !== ea || fb_data !== pv) begin
                    errors++;
                    $display("FAIL pixel l%0d x%0d: we=%b addr=%h data=%0d, expected we=1 addr=%h data=%0d",
                             line, i, fb_we, fb_addr, fb_data, ea, pv);
                end
            end else if (fb_we !== 1'b0) begin
                errors++;
                $display("FAIL nowrite l%0d x%0d: we=%b addr=%h, expected we=0", line, i, fb_we, fb_addr);
            end
        end
        px_valid = 1'b0;
    endtask

    task automatic draw_line(input int line, input int npix, input logic bank, input bit exp_wr);
        ppu_mode = 2'd2; tick();
        ppu_mode = 2'd3; tick();
        push_pixels(line, npix, bank, exp_wr);
        ppu_mode = 2'd0; tick();
    endtask

    task automatic run_frame(input int short_line, input int ovf_line, input logic bank);
        int n;
        for (int l = 0; l < 144; l++) begin
            n = 160;
            if (l == short_line) n = 159;
            if (l == ovf_line) n = 165;
            draw_line(l, n, bank, 1'b1);
        end
        ppu_mode = 2'd1; tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 7;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL reset fb_we: got %b, expected 0", fb_we); end
        if (fb_addr !== 16'h0) begin errors++; $display("FAIL reset fb_addr: got %h, expected 0000", fb_addr); end
        if (fb_data !== 2'd0) begin errors++; $display("FAIL reset fb_data: got %0d, expected 0", fb_data); end
        if (disp_bank !== 1'b1) begin errors++; $display("FAIL reset disp_bank: got %b, expected 1", disp_bank); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b, expected 0", frame_done); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b, expected 0", frame_err); end
        if (line_cnt !== 8'd0) begin errors++; $display("FAIL reset line_cnt: got %0d, expected 0", line_cnt); end
        rst = 1'b0;
        // Dummy frame tail: pixels while still waiting for sync write nothing.
        clear_stats();
        draw_line(0, 6, 1'b0, 1'b0);
        ppu_mode = 2'd1; tick(); tick();
        checks++;
        if (wr_cnt != 0 || done_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL sync_wait: writes=%0d done=%0d err=%0d, expected all 0", wr_cnt, done_cnt, err_cnt);
        end
    endtask

    task automatic test_palette();
        logic [1:0] exp_pal [4];
        exp_pal = '{2'd3, 2'd2, 2'd1, 2'd0};
        clear_stats();
        ppu_mode = 2'd2; tick();
        ppu_mode = 2'd3; tick();
        bgp = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            px_valid = 1'b1;
            px_in    = 2'(i);
            tick();
            checks++;
            if (fb_we !== 1'b1 || fb_data !== exp_pal[i] || fb_addr !== 16'(i)) begin
                errors++;
                $display("FAIL palette px%0d: we=%b data=%0d addr=%h, expected we=1 data=%0d addr=%h",
                         i, fb_we, fb_data, fb_addr, exp_pal[i], 16'(i));
            end
        end
        bgp   = 8'hE4;
        px_in = 2'd1;
        tick();
        checks++;
        if (fb_we !== 1'b1 || fb_data !== 2'd1 || fb_addr !== 16'h0004) begin
            errors++;
            $display("FAIL palette_change: we=%b data=%0d addr=%h, expected we=1 data=1 addr=0004", fb_we, fb_data, fb_addr);
        end
        px_valid = 1'b0;
        tick();
        checks++;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL strobe_width: we=%b, expected 0", fb_we); end
        // V-blank in the middle of the line: truncated, incomplete frame.
        ppu_mode = 2'd1; tick();
        checks++;
        if (frame_err !== 1'b1 || frame_done !== 1'b0 || disp_bank !== 1'b1 || line_cnt !== 8'd0) begin
            errors++;
            $display("FAIL truncated_vb: err=%b done=%b disp=%b line=%0d, expected err=1 done=0 disp=1 line=0",
                     frame_err, frame_done, disp_bank, line_cnt);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL err_pulse: err=%b, expected 0", frame_err); end
    endtask

    task automatic test_short_line();
        clear_stats();
        run_frame(50, -1, 1'b0);
        checks += 3;
        if (err_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL short_status: err pulses=%0d done pulses=%0d, expected 1 and 0", err_cnt, done_cnt);
        end
        if (disp_bank !== 1'b1) begin errors++; $display("FAIL short_disp: got %b, expected 1", disp_bank); end
        if (wr_cnt != 23039 || line_cnt !== 8'd144) begin
            errors++;
            $display("FAIL short_writes: writes=%0d line=%0d, expected 23039 and 144", wr_cnt, line_cnt);
        end
    endtask

    task automatic test_full_frame();
        clear_stats();
        run_frame(-1, -1, 1'b0);
        checks += 4;
        if (wr_cnt != 23040) begin errors++; $display("FAIL full_writes: got %0d, expected 23040", wr_cnt); end
        if (a0_addr !== 16'h00A0 || last_addr !== 16'h59FF) begin
            errors++;
            $display("FAIL full_addr: l1x0=%h last=%h, expected 00a0 and 59ff", a0_addr, last_addr);
        end
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL full_status: done pulses=%0d err pulses=%0d, expected 1 and 0", done_cnt, err_cnt);
        end
        if (disp_bank !== 1'b0) begin errors++; $display("FAIL full_disp: got %b, expected 0", disp_bank); end
    endtask

    task automatic test_overflow();
        clear_stats();
        run_frame(-1, 10, 1'b1);
        checks += 3;
        if (wr_cnt != 23040 || last_addr !== 16'hD9FF) begin
            errors++;
            $display("FAIL ovf_writes: writes=%0d last=%h, expected 23040 and d9ff", wr_cnt, last_addr);
        end
        if (err_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL ovf_status: err pulses=%0d done pulses=%0d, expected 1 and 0", err_cnt, done_cnt);
        end
        if (disp_bank !== 1'b0) begin errors++; $display("FAIL ovf_disp: got %b, expected 0", disp_bank); end
    endtask

    task automatic test_lcd_drop();
        for (int l = 0; l < 70; l++) draw_line(l, 0, 1'b1, 1'b1);
        ppu_mode = 2'd2; tick();
        ppu_mode = 2'd3; tick();
        checks++;
        if (line_cnt !== 8'd70) begin errors++; $display("FAIL lcd_line: got %0d, expected 70", line_cnt); end
        push_pixels(70, 3, 1'b1, 1'b1);
        lcd_en   = 1'b0;
        px_valid = 1'b1;
        tick();
        checks++;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL lcd_off_we: got %b, expected 0", fb_we); end
        clear_stats();
        tick(); tick(); tick();
        lcd_en   = 1'b1;
        px_valid = 1'b0;
        ppu_mode = 2'd0; tick();
        draw_line(0, 8, 1'b1, 1'b0);
        draw_line(1, 8, 1'b1, 1'b0);
        ppu_mode = 2'd1; tick(); tick();
        checks++;
        if (wr_cnt != 0 || done_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL lcd_resync: writes=%0d done=%0d err=%0d, expected all 0", wr_cnt, done_cnt, err_cnt);
        end
        clear_stats();
        draw_line(0, 8, 1'b1, 1'b1);
        checks++;
        if (wr_cnt != 8) begin errors++; $display("FAIL lcd_resume: writes=%0d, expected 8", wr_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int l = 1; l < 30; l++) draw_line(l, 0, 1'b1, 1'b1);
        ppu_mode = 2'd2; tick();
        ppu_mode = 2'd3; tick();
        push_pixels(30, 3, 1'b1, 1'b1);
        px_valid = 1'b1;
        rst      = 1'b1;
        tick();
        checks += 7;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL midrst fb_we: got %b, expected 0", fb_we); end
        if (fb_addr !== 16'h0) begin errors++; $display("FAIL midrst fb_addr: got %h, expected 0000", fb_addr); end
        if (fb_data !== 2'd0) begin errors++; $display("FAIL midrst fb_data: got %0d, expected 0", fb_data); end
        if (disp_bank !== 1'b1) begin errors++; $display("FAIL midrst disp_bank: got %b, expected 1", disp_bank); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst frame_done: got %b, expected 0", frame_done); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst frame_err: got %b, expected 0", frame_err); end
        if (line_cnt !== 8'd0) begin errors++; $display("FAIL midrst line_cnt: got %0d, expected 0", line_cnt); end
        rst = 1'b0;
        clear_stats();
        tick(); tick(); tick(); tick();
        px_valid = 1'b0;
        checks++;
        if (wr_cnt != 0) begin errors++; $display("FAIL midrst_nowrite: writes=%0d, expected 0", wr_cnt); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        lcd_en   = 1'b1;
        ppu_mode = 2'd0;
        px_in    = 2'd0;
        px_valid = 1'b0;
        bgp      = 8'hE4;
        clear_stats();
        test_reset();
        test_palette();
        test_short_line();
        test_full_frame();
        test_overflow();
        test_lcd_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
